// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for serial_subtractor.
// The master issues operands and start; the slave returns status and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one bit per cycle, LSB first, through a single full-subtractor cell.
// The result and flags are latched on the edge that enters DONE; done pulses one cycle later.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic sub_bit(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             d_bit_s;
  logic             br_next_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  // Next-state, datapath and result-capture logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    d_bit_s    = sub_bit(a_q[0], b_q[0], br_q);
    br_next_s  = sub_borrow(a_q[0], b_q[0], br_q);
    res_next_s = {d_bit_s, res_q[WIDTH-1:1]};
    last_s     = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_next_s;
        br_d  = br_next_s;
        cnt_d = cnt_q + CW'(1);
        // Operand MSBs are kept aside because the shift registers have lost them by now.
        if (last_s) begin
          state_d  = DONE;
          diff_d   = res_next_s;
          borrow_d = br_next_s;
          ovf_d    = (a_msb_q != b_msb_q) && (res_next_s[WIDTH-1] != a_msb_q);
          zero_d   = ~|res_next_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_q == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (WIDTH=8 and WIDTH=32 instances),
// checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [63:0] prev_d;
  logic        prev_br, prev_ov, prev_z;

  serial_subtractor_if #(.WIDTH(W))  s8 ();
  serial_subtractor_if #(.WIDTH(32)) s32 ();

  serial_subtractor #(.WIDTH(W))  dut8  (.clk(clk), .reset(reset), .bus(s8));
  serial_subtractor #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(s32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_sub(input int w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] d, output logic br, output logic ov,
                                  output logic z);
    longint half;
    longint sa;
    longint sb;
    longint sd;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    half = longint'(64'd1 << (w - 1));
    d    = (a - b) & mask;
    br   = (a < b);
    sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    sd   = sa - sb;
    ov   = (sd >= half) || (sd < -half);
    z    = (d == 64'd0);
  endfunction

  task automatic check_prev(input string tag);
    check({tag, "_diff_hold"}, s8.diff, prev_d);
    check({tag, "_borrow_hold"}, s8.borrow_out, prev_br);
    check({tag, "_ovf_hold"}, s8.overflow, prev_ov);
    check({tag, "_zero_hold"}, s8.zero, prev_z);
  endtask

  // One WIDTH=8 operation; intrude>0 pulses a competing start at that RUN cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int intrude);
    logic [63:0] ed;
    logic ebr, eov, ez;
    ref_sub(W, 64'(a), 64'(b), ed, ebr, eov, ez);
    s8.a = a;
    s8.b = b;
    s8.start = 1'b1;
    @(posedge clk); #1;
    s8.start = 1'b0;
    check("busy_accept", s8.busy, 1'b1);
    for (int n = 1; n <= W + 2; n++) begin
      if (n == intrude) begin
        s8.start = 1'b1;
        s8.a = 8'hFF;
        s8.b = 8'h00;
      end else begin
        s8.start = 1'b0;
      end
      @(posedge clk); #1;
      check("done_timing", s8.done, (n == W + 1));
      check("busy", s8.busy, (n < W));
      if (n == 2 || n == W - 1) check_prev("run");
      if (n == W + 1) begin
        check("diff", s8.diff, ed);
        check("borrow_out", s8.borrow_out, ebr);
        check("overflow", s8.overflow, eov);
        check("zero", s8.zero, ez);
      end
    end
    prev_d = ed; prev_br = ebr; prev_ov = eov; prev_z = ez;
  endtask

  task automatic b2b8();
    logic [7:0] av[5];
    logic [7:0] bv[5];
    logic [63:0] ed;
    logic ebr, eov, ez;
    for (int i = 0; i < 5; i++) begin
      av[i] = 8'($urandom_range(0, 255));
      bv[i] = 8'($urandom_range(0, 255));
    end
    s8.a = av[0];
    s8.b = bv[0];
    s8.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      ref_sub(W, 64'(av[i]), 64'(bv[i]), ed, ebr, eov, ez);
      if (i < 4) begin
        s8.a = av[i + 1];
        s8.b = bv[i + 1];
      end else begin
        s8.start = 1'b0;
      end
      for (int n = 1; n <= W + 1; n++) begin
        @(posedge clk); #1;
        check("b2b_done", s8.done, (n == W + 1));
        if (n == 3) check_prev("b2b");
      end
      check("b2b_busy", s8.busy, (i < 4));
      check("b2b_diff", s8.diff, ed);
      check("b2b_borrow", s8.borrow_out, ebr);
      check("b2b_ovf", s8.overflow, eov);
      check("b2b_zero", s8.zero, ez);
      prev_d = ed; prev_br = ebr; prev_ov = eov; prev_z = ez;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, s8.busy, 1'b0);
    check({tag, "_done"}, s8.done, 1'b0);
    check({tag, "_diff"}, s8.diff, 8'h00);
    check({tag, "_borrow"}, s8.borrow_out, 1'b0);
    check({tag, "_ovf"}, s8.overflow, 1'b0);
    check({tag, "_zero"}, s8.zero, 1'b1);
  endtask

  initial begin
    logic seen_done;
    int   lat;
    n_checks = 0;
    n_fail   = 0;
    prev_d = 64'd0; prev_br = 1'b0; prev_ov = 1'b0; prev_z = 1'b1;
    s32.start = 1'b0; s32.a = 32'd0; s32.b = 32'd0;

    // Reset asserted together with start: reset must win.
    reset = 1'b1;
    s8.start = 1'b1; s8.a = 8'h12; s8.b = 8'h34;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    s8.start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", s8.busy, 1'b0);

    op8(8'h05, 8'h03, 0);
    op8(8'h03, 8'h05, 0);
    op8(8'h80, 8'h01, 0);
    op8(8'h55, 8'h55, 0);
    op8(8'h00, 8'hFF, 0);
    op8(8'h10, 8'h01, 3);
    for (int i = 0; i < 10; i++) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);

    // Reset in the middle of RUN aborts without a result update.
    s8.a = 8'h33; s8.b = 8'h11; s8.start = 1'b1;
    @(posedge clk); #1;
    s8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals("abort");
    seen_done = 1'b0;
    for (int n = 0; n < W + 3; n++) begin
      @(posedge clk); #1;
      seen_done = seen_done | s8.done | s8.busy;
    end
    check("abort_no_done", seen_done, 1'b0);
    prev_d = 64'd0; prev_br = 1'b0; prev_ov = 1'b0; prev_z = 1'b1;
    op8(8'h09, 8'h02, 0);

    b2b8();

    // Wide instance: 0 - 1 wraps to all ones with a borrow.
    s32.a = 32'h0000_0000; s32.b = 32'h0000_0001; s32.start = 1'b1;
    @(posedge clk); #1;
    s32.start = 1'b0;
    lat = 0;
    while (lat < 100 && s32.done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w32_latency", 64'(lat), 64'd33);
    check("w32_diff", s32.diff, 32'hFFFF_FFFF);
    check("w32_borrow", s32.borrow_out, 1'b1);
    check("w32_ovf", s32.overflow, 1'b0);
    check("w32_zero", s32.zero, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
